// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
//   processed CHUNK bits per clock, with the inter-slice carry held in a
//   register. Operands are taken on an in_valid/in_ready handshake. The result
//   and flags are held on an out_valid/out_ready handshake until they are
//   consumed.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of CHUNK
//   CHUNK      bits added per clock (NCH = WIDTH/CHUNK cycles in RUN)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair present           in_ready  block can accept
//   a, b       operands                       mode      0: a+b, 1: a-b
//   out_valid  result/flags valid             out_ready consumer takes result
//   s          result modulo 2^WIDTH
//   c          carry out of MSB (subtract: 1 = no borrow)
//   v          signed overflow   z  s == 0   n  s[WIDTH-1]
// -----------------------------------------------------------------------------
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, rb_q;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  int                 sh;
  logic [CHUNK-1:0]   ra_sl, rb_sl;
  logic [CHUNK:0]     slice_sum;
  logic [WIDTH-1:0]   s_new;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Operand registers hold no control meaning, so they load only on accept.
  // NOTE: datapath registers that are always written before being read need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra_q <= a;
      rb_q <= b ^ {WIDTH{mode}};  // subtract as a + ~b + 1 (carry-in = mode)
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latches are inferred.
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    s_d         = s_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;

    // Current slice of each operand and its sum with the rippled carry.
    sh        = int'(idx_q) * CHUNK;
    ra_sl     = CHUNK'(ra_q >> sh);
    rb_sl     = CHUNK'(rb_q >> sh);
    slice_sum = {1'b0, ra_sl} + {1'b0, rb_sl} + (CHUNK + 1)'(carry_q);
    s_new     = (s_q & ~(WIDTH'({CHUNK{1'b1}}) << sh))
              | (WIDTH'(slice_sum[CHUNK-1:0]) << sh);

    case (state_q)
      IDLE: begin
        if (accept) begin
          carry_d = mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_new;
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          c_d         = slice_sum[CHUNK];
          // Overflow: operands agree in sign (rb already inverted for subtract)
          // but the result sign differs.
          v_d         = (ra_q[WIDTH-1] == rb_q[WIDTH-1]) &&
                        (s_new[WIDTH-1] != ra_q[WIDTH-1]);
          z_d         = (s_new == '0);
          n_d         = s_new[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c         = c_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq
//   Directed testbench for addsub_seq. Two instances share clk/rst: a default
//   16-bit / 4-bit-chunk core and an 8-bit single-chunk core. Inputs are driven
//   and outputs sampled on the falling edge. Expected results are hand-computed
//   and packed as {s, c, v, z, n}.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

  logic        clk;
  logic        rst;

  logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16;
  logic [15:0] a16, b16, s16;
  logic        c16, v16, z16, n16;

  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, s8;
  logic        c8, v8, z8, n8;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .s(s16), .c(c16), .v(v16), .z(z16), .n(n16)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c(c8), .v(v8), .z(z8), .n(n8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starting on the falling edge after the accept edge, count edges until
  // out_valid rises (bounded).
  task automatic wait16(output int lat, output logic [19:0] obs);
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs = {s16, c16, v16, z16, n16};
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                       output int lat, output logic [19:0] obs);
    @(negedge clk);
    a16 = ta; b16 = tb; mode16 = tm; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    wait16(lat, obs);
  endtask

  task automatic release16();
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                      output int lat, output logic [11:0] obs);
    @(negedge clk);
    a8 = ta; b8 = tb; mode8 = tm; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs = {s8, c8, v8, z8, n8};
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready16, in_ready8} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_in_ready_low: got %b want 00", {in_ready16, in_ready8});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid16, s16, c16, v16, z16, n16} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_outputs16: got %h want 0", {out_valid16, s16, c16, v16, z16, n16});
    end
    n_cmp++;
    if ({out_valid8, s8, c8, v8, z8, n8} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs8: got %h want 0", {out_valid8, s8, c8, v8, z8, n8});
    end
    n_cmp++;
    if ({in_ready16, in_ready8} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_in_ready_high: got %b want 11", {in_ready16, in_ready8});
    end
  endtask

  // One 16-bit operation: check latency and {s,c,v,z,n}, then consume it.
  task automatic test_vector16(input string name, input logic [15:0] ta,
                               input logic [15:0] tb, input logic tm,
                               input logic [19:0] exp);
    int          lat;
    logic [19:0] obs;
    run16(ta, tb, tm, lat, obs);
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s_result: got s=%h cvzn=%b want s=%h cvzn=%b",
               name, obs[19:4], obs[3:0], exp[19:4], exp[3:0]);
    end
    release16();
  endtask

  task automatic test_add();
    test_vector16("add",      16'h1234, 16'h0FF1, 1'b0, {16'h2225, 4'b0000});
  endtask

  task automatic test_carry_ripple();
    test_vector16("ripple",   16'hFFFF, 16'h0001, 1'b0, {16'h0000, 4'b1010});
  endtask

  task automatic test_overflow();
    test_vector16("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0101});
  endtask

  task automatic test_subtract();
    test_vector16("sub_ovf",  16'h8000, 16'h0001, 1'b1, {16'h7FFF, 4'b1100});
    test_vector16("sub_zero", 16'h5A5A, 16'h5A5A, 1'b1, {16'h0000, 4'b1010});
    test_vector16("sub_borrow", 16'h0003, 16'h0005, 1'b1, {16'hFFFE, 4'b0001});
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [19:0] obs;
    run16(16'h1111, 16'h2222, 1'b0, lat, obs);
    // Stall in DONE while offering new operands.
    a16 = 16'hFFFF; b16 = 16'hFFFF; mode16 = 1'b0; in_valid16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid16, in_ready16, s16, c16, v16, z16, n16} !== {2'b10, 16'h3333, 4'b0000}) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: got ov/ir=%b%b s=%h cvzn=%b want ov/ir=10 s=3333 cvzn=0000",
                 i, out_valid16, in_ready16, s16, {c16, v16, z16, n16});
      end
    end
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    n_cmp++;
    if ({out_valid16, in_ready16} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_release: got ov/ir=%b%b want 01", out_valid16, in_ready16);
    end
    // in_valid is still high: the pending operands are accepted at this edge.
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    wait16(lat, obs);
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL after_stall_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (obs !== {16'hFFFE, 4'b1001}) begin
      n_bad++;
      $display("FAIL after_stall_result: got s=%h cvzn=%b want s=fffe cvzn=1001",
               obs[19:4], obs[3:0]);
    end
    release16();
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; mode16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);                 // accept
    @(negedge clk);
    in_valid16 = 1'b0;
    @(posedge clk);                 // first RUN edge
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);                 // second RUN edge: reset wins
    @(negedge clk);
    n_cmp++;
    if (in_ready16 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_in_ready_in_rst: got %b want 0", in_ready16);
    end
    n_cmp++;
    if ({out_valid16, s16, c16, v16, z16, n16} !== 21'h0) begin
      n_bad++;
      $display("FAIL midrun_outputs: got %h want 0", {out_valid16, s16, c16, v16, z16, n16});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready16 !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_in_ready_after: got %b want 1", in_ready16);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid16) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_discarded: got out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_single_chunk();
    int          lat;
    logic [11:0] obs;
    run8(8'h7F, 8'h01, 1'b0, lat, obs);
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL w8_add_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (obs !== {8'h80, 4'b0101}) begin
      n_bad++;
      $display("FAIL w8_add_result: got s=%h cvzn=%b want s=80 cvzn=0101", obs[11:4], obs[3:0]);
    end
    run8(8'h80, 8'h01, 1'b1, lat, obs);
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL w8_sub_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (obs !== {8'h7F, 4'b1100}) begin
      n_bad++;
      $display("FAIL w8_sub_result: got s=%h cvzn=%b want s=7f cvzn=1100", obs[11:4], obs[3:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; mode16 = 1'b0; out_ready16 = 1'b0;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; mode8  = 1'b0; out_ready8  = 1'b0;
    test_reset();
    test_add();
    test_carry_ripple();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_single_chunk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
